// File: rtl/rc4_smem_sequencer_if.sv
// RC4 S-memory sequencer bus: lab-top control, engine handshakes
// and the shared single-port S RAM port.
interface rc4_smem_sequencer_if;
  logic        start;
  logic        abort;
  logic [23:0] secret_key;
  logic [23:0] key_out;
  logic        eng_clr;
  logic        init_on;
  logic        ksa_on;
  logic        prga_on;
  logic        init_fin;
  logic        ksa_fin;
  logic        prga_fin;
  logic [7:0]  init_addr;
  logic [7:0]  ksa_addr;
  logic [7:0]  prga_addr;
  logic [7:0]  init_data;
  logic [7:0]  ksa_data;
  logic [7:0]  prga_data;
  logic        init_wren;
  logic        ksa_wren;
  logic        prga_wren;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_data;
  logic        mem_wren;
  logic        busy;
  logic        done;
  logic        fault;
  logic [2:0]  phase;

  modport slave (
    input  start, abort, secret_key,
    input  init_fin, ksa_fin, prga_fin,
    input  init_addr, ksa_addr, prga_addr,
    input  init_data, ksa_data, prga_data,
    input  init_wren, ksa_wren, prga_wren,
    output key_out, eng_clr,
    output init_on, ksa_on, prga_on,
    output mem_addr, mem_data, mem_wren,
    output busy, done, fault, phase
  );

  modport master (
    output start, abort, secret_key,
    output init_fin, ksa_fin, prga_fin,
    output init_addr, ksa_addr, prga_addr,
    output init_data, ksa_data, prga_data,
    output init_wren, ksa_wren, prga_wren,
    input  key_out, eng_clr,
    input  init_on, ksa_on, prga_on,
    input  mem_addr, mem_data, mem_wren,
    input  busy, done, fault, phase
  );
endinterface

// File: rtl/rc4_smem_sequencer.sv
// RC4 phase sequencer: S-init, KSA, PRGA in order, S RAM grant,
// key latch and per-phase watchdog.
module rc4_smem_sequencer #(
  parameter int TIMEOUT_CYCLES = 8192,
  parameter int CNT_W          = 16
) (
  input logic                 clk,
  input logic                 reset_n,
  rc4_smem_sequencer_if.slave bus
);

  // low 3 bits are the phase code; FAULT aliases DONE's code 7
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CLR   = 4'd1,
    S_INIT  = 4'd2,
    S_GAP1  = 4'd3,
    S_KSA   = 4'd4,
    S_GAP2  = 4'd5,
    S_PRGA  = 4'd6,
    S_DONE  = 4'd7,
    S_FAULT = 4'd15
  } state_t;

  localparam logic [CNT_W-1:0] WD_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_ONE = CNT_W'(1);

  state_t           state;
  state_t           state_nx;
  logic [23:0]      key_q;
  logic [CNT_W-1:0] wd;
  logic             take;
  logic             in_ph;
  logic             tmo;
  logic             busy_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      key_q <= '0;
      wd    <= '0;
    end else begin
      state <= state_nx;
      if (take) key_q <= bus.secret_key;
      if (state_nx != state) wd <= '0;
      else if (in_ph) wd <= wd + WD_ONE;
    end
  end

  assign tmo         = (wd == WD_MAX);
  assign bus.key_out = key_q;
  assign bus.phase   = state[2:0];
  assign bus.busy    = busy_c;

  always_comb begin
    state_nx     = state;
    take         = 1'b0;
    in_ph        = 1'b0;
    busy_c       = 1'b0;
    bus.eng_clr  = 1'b0;
    bus.init_on  = 1'b0;
    bus.ksa_on   = 1'b0;
    bus.prga_on  = 1'b0;
    bus.mem_addr = '0;
    bus.mem_data = '0;
    bus.mem_wren = 1'b0;
    bus.done     = 1'b0;
    bus.fault    = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_FAULT: begin
        bus.done  = (state == S_DONE);
        bus.fault = (state == S_FAULT);
        if (bus.start) begin
          state_nx = S_CLR;
          take     = 1'b1;
        end
      end
      S_CLR: begin
        busy_c      = 1'b1;
        bus.eng_clr = 1'b1;
        state_nx    = S_INIT;
      end
      S_INIT: begin
        busy_c       = 1'b1;
        in_ph        = 1'b1;
        bus.init_on  = 1'b1;
        bus.mem_addr = bus.init_addr;
        bus.mem_data = bus.init_data;
        bus.mem_wren = bus.init_wren;
        if (bus.init_fin) state_nx = S_GAP1;
        else if (tmo)     state_nx = S_FAULT;
      end
      S_GAP1: begin
        busy_c   = 1'b1;
        state_nx = S_KSA;
      end
      S_KSA: begin
        busy_c       = 1'b1;
        in_ph        = 1'b1;
        bus.ksa_on   = 1'b1;
        bus.mem_addr = bus.ksa_addr;
        bus.mem_data = bus.ksa_data;
        bus.mem_wren = bus.ksa_wren;
        if (bus.ksa_fin) state_nx = S_GAP2;
        else if (tmo)    state_nx = S_FAULT;
      end
      S_GAP2: begin
        busy_c   = 1'b1;
        state_nx = S_PRGA;
      end
      S_PRGA: begin
        busy_c       = 1'b1;
        in_ph        = 1'b1;
        bus.prga_on  = 1'b1;
        bus.mem_addr = bus.prga_addr;
        bus.mem_data = bus.prga_data;
        bus.mem_wren = bus.prga_wren;
        if (bus.prga_fin) state_nx = S_DONE;
        else if (tmo)     state_nx = S_FAULT;
      end
      default: state_nx = S_IDLE;
    endcase
    if (busy_c && bus.abort) state_nx = S_IDLE;
  end

endmodule

// File: tb/tb_rc4_smem_sequencer.sv
// Randomized scoreboard bench for rc4_smem_sequencer: phase events
// against a duration model, per-cycle output/grant checks.
module tb_rc4_smem_sequencer;

  localparam int T = 8192;

  typedef struct {
    int          ph;
    bit          flt;
    logic [23:0] key;
    int          dur;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rc4_smem_sequencer_if bus();

  rc4_smem_sequencer #(
    .TIMEOUT_CYCLES(T),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  ev_t q[$];
  int  checks = 0;
  int  failures = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // engine stubs: fin rises after n active cycles, cleared by eng_clr
  int n_i, n_k, n_p;
  int c_i, c_k, c_p;
  bit iso;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_i <= 0; c_k <= 0; c_p <= 0;
    end else if (bus.eng_clr) begin
      c_i <= 0; c_k <= 0; c_p <= 0;
    end else begin
      if (bus.init_on) c_i <= c_i + 1;
      if (bus.ksa_on)  c_k <= c_k + 1;
      if (bus.prga_on) c_p <= c_p + 1;
    end
  end

  assign bus.init_fin = (c_i >= n_i);
  assign bus.ksa_fin  = (c_k >= n_k);
  assign bus.prga_fin = (c_p >= n_p);

  always @(posedge clk) begin
    #2;
    bus.ksa_addr  = 8'($urandom);
    bus.ksa_data  = 8'($urandom);
    bus.ksa_wren  = 1'($urandom);
    bus.init_data = 8'($urandom);
    bus.prga_data = 8'($urandom);
    if (iso) begin
      bus.init_addr = 8'h55; bus.init_wren = 1'b1;
      bus.prga_addr = 8'h55; bus.prga_wren = 1'b1;
    end else begin
      bus.init_addr = 8'($urandom); bus.init_wren = 1'($urandom);
      bus.prga_addr = 8'($urandom); bus.prga_wren = 1'($urandom);
    end
  end

  // reference model: phase event list from fin delays and timeout
  function automatic int pdur(input int n);
    return (n < T) ? n + 1 : T;
  endfunction

  task automatic push(input int ph, input bit f, input logic [23:0] k, input int d);
    ev_t e;
    e.ph = ph; e.flt = f; e.key = k; e.dur = d;
    q.push_back(e);
  endtask

  task automatic expect_run(input logic [23:0] k, input int a, input int b,
                            input int c, input int cut_ph, input int cut_dur,
                            input bit rst);
    int n[3];
    int prev;
    n[0] = a; n[1] = b; n[2] = c;
    push(1, 0, k, -1);
    prev = 1;
    for (int e = 0; e < 3; e++) begin
      int ph;
      ph = 2 + 2 * e;
      push(ph, 0, k, prev);
      if (cut_ph == ph) begin
        push(0, 0, rst ? 24'h0 : k, cut_dur);
        return;
      end
      if (n[e] >= T) begin
        push(7, 1, k, T);
        return;
      end
      if (e < 2) begin
        push(ph + 1, 0, k, pdur(n[e]));
        prev = 1;
      end else begin
        push(7, 0, k, pdur(n[e]));
      end
    end
  endtask

  // monitor
  logic [3:0]  last = 4'd0;
  int          cyc = 0;
  int          last_cyc = 0;

  always @(negedge clk) begin
    logic [2:0]  ph;
    logic [16:0] m;
    logic [22:0] act;
    logic [22:0] exp;
    ev_t         e;
    ph = bus.phase;
    cyc++;
    case (ph)
      3'd2:    m = {bus.init_addr, bus.init_data, bus.init_wren};
      3'd4:    m = {bus.ksa_addr, bus.ksa_data, bus.ksa_wren};
      3'd6:    m = {bus.prga_addr, bus.prga_data, bus.prga_wren};
      default: m = '0;
    endcase
    exp = {ph == 3'd2, ph == 3'd4, ph == 3'd6, ph == 3'd1,
           (ph >= 3'd1 && ph <= 3'd6), (ph == 3'd7 && !bus.fault), m};
    act = {bus.init_on, bus.ksa_on, bus.prga_on, bus.eng_clr,
           bus.busy, bus.done, bus.mem_addr, bus.mem_data, bus.mem_wren};
    chk("outputs", act, exp);
    if ({bus.fault, ph} != last) begin
      chk("sb_event_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("ev_phase", ph, e.ph);
        chk("ev_fault", bus.fault, e.flt);
        chk("ev_key", bus.key_out, e.key);
        if (e.dur >= 0) chk("ev_dur", cyc - last_cyc, e.dur);
      end
      last = {bus.fault, ph};
      last_cyc = cyc;
    end
  end

  task automatic do_start(input logic [23:0] k, input bit ab);
    @(negedge clk);
    bus.secret_key = k;
    bus.start = 1'b1;
    bus.abort = ab;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int i;
    i = 0;
    while (!(bus.done || bus.fault) && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("run_finished", bus.done || bus.fault, 1);
  endtask

  task automatic wait_phase(input logic [2:0] p, input int budget);
    int i;
    i = 0;
    while (bus.phase != p && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("phase_reached", bus.phase, p);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [23:0] k;
    bus.start = 1'b0; bus.abort = 1'b0; bus.secret_key = 24'h0;
    iso = 1'b0;
    n_i = 260; n_k = 3080; n_p = 100;
    repeat (3) @(negedge clk);
    chk("reset_state",
        {bus.phase, bus.key_out, bus.busy, bus.done, bus.fault, bus.mem_wren},
        0);
    reset_n = 1'b1;

    // normal run, grant isolation, key stability
    iso = 1'b1;
    expect_run(24'h000249, n_i, n_k, n_p, -1, 0, 0);
    do_start(24'h000249, 1'b0);
    bus.secret_key = 24'hFFFFFF;
    wait_end(5000);
    chk("run1_key", bus.key_out, 24'h000249);
    chk("run1_done", {bus.done, bus.busy, bus.fault}, 3'b100);
    iso = 1'b0;

    // watchdog fires in KSA
    n_i = $urandom_range(0, 300); n_k = 100000; n_p = $urandom_range(0, 300);
    k = 24'($urandom);
    expect_run(k, n_i, n_k, n_p, -1, 0, 0);
    do_start(k, 1'b0);
    wait_end(T + 1000);
    chk("tmo_state", {bus.fault, bus.phase, bus.ksa_on}, {1'b1, 3'd7, 1'b0});

    // fin on the last counted cycle wins
    n_k = T - 1;
    k = 24'($urandom);
    expect_run(k, n_i, n_k, n_p, -1, 0, 0);
    do_start(k, 1'b0);
    wait_end(T + 1000);
    chk("edge_done", {bus.done, bus.fault}, 2'b10);

    // abort in KSA at cycle 500
    n_k = 3080;
    k = 24'($urandom);
    expect_run(k, n_i, n_k, n_p, 4, 501, 0);
    do_start(k, 1'b0);
    wait_phase(3'd4, 2000);
    repeat (500) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_state",
        {bus.phase, bus.init_on, bus.ksa_on, bus.prga_on, bus.mem_wren},
        0);
    chk("abort_key", bus.key_out, k);
    bus.abort = 1'b1;
    repeat (3) @(negedge clk);
    bus.abort = 1'b0;

    // start wins over abort in IDLE; key relatched
    n_i = $urandom_range(0, 300); n_k = $urandom_range(0, 300);
    n_p = $urandom_range(0, 300);
    expect_run(24'h123456, n_i, n_k, n_p, -1, 0, 0);
    do_start(24'h123456, 1'b1);
    wait_end(2000);
    chk("relatch_key", bus.key_out, 24'h123456);

    // async reset mid-PRGA
    n_p = 200;
    k = 24'($urandom);
    expect_run(k, n_i, n_k, n_p, 6, -1, 1);
    do_start(k, 1'b0);
    wait_phase(3'd6, 2000);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_reset",
        {bus.phase, bus.key_out, bus.prga_on, bus.busy, bus.mem_addr,
         bus.mem_data, bus.mem_wren},
        0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int r = 0; r < 3; r++) begin
      n_i = $urandom_range(0, 400); n_k = $urandom_range(0, 400);
      n_p = $urandom_range(0, 400);
      k = 24'($urandom);
      expect_run(k, n_i, n_k, n_p, -1, 0, 0);
      do_start(k, 1'b0);
      wait_end(2000);
      chk("rand_done", {bus.done, bus.key_out}, {1'b1, k});
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rc4_smem_sequencer.md
Name: rc4_smem_sequencer

Overview:
- Top-level controller for the RC4 S-memory pipeline.
- Runs the three phases in order: S-init (s[i]=i), key scheduling (KSA) and PRGA/decrypt.
- Gives the single-port 256x8 S RAM to exactly one phase engine at a time, latches the secret key and watches each phase with a timeout.
- Sits between the lab top level (switches/keys, or a key-search loop) and the three phase engines.

Parameters:
- TIMEOUT_CYCLES, 8192: maximum cycles a phase may stay active before FAULT.
- CNT_W, 16: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk in 1: system clock, all logic on rising edge.
- reset_n in 1: asynchronous active-low reset.
- start in 1: one-cycle request to begin a full run. Accepted in IDLE, DONE and FAULT.
- abort in 1: synchronous abort of a running sequence.
- secret_key in 24: key sampled on accepted start.
- key_out out 24: latched key driven to the KSA and PRGA engines.
- eng_clr out 1: one-cycle pulse that clears all phase engines before INIT.
- init_on, ksa_on, prga_on out 1 each: level enables, one per engine.
- init_fin, ksa_fin, prga_fin in 1 each: level finished flags from the engines.
- init_addr/ksa_addr/prga_addr in 8: requester RAM addresses.
- init_data/ksa_data/prga_data in 8: requester RAM write data.
- init_wren/ksa_wren/prga_wren in 1: requester RAM write enables.
- mem_addr out 8, mem_data out 8, mem_wren out 1: S RAM port. RAM q returns directly to the engines.
- busy out 1: high in CLR, INIT, GAP1, KSA, GAP2, PRGA.
- done out 1: high in DONE.
- fault out 1: high in FAULT.
- phase out 3: state code, encoded IDLE=0 CLR=1 INIT=2 GAP1=3 KSA=4 GAP2=5 PRGA=6 DONE/FAULT=7. Use fault to tell DONE from FAULT.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, key_out=0, watchdog=0.
  - All *_on=0, eng_clr=0, mem_addr=mem_data=0, mem_wren=0.
  - busy=done=fault=0.
- State transitions, all on rising clk:
  - IDLE -> CLR on start=1; key_out<=secret_key on that edge.
  - CLR: eng_clr=1 for exactly this one cycle -> INIT.
  - INIT: init_on=1. When init_fin=1 -> GAP1.
  - GAP1: no grant for one cycle -> KSA.
  - KSA: ksa_on=1. When ksa_fin=1 -> GAP2.
  - GAP2: no grant for one cycle -> PRGA.
  - PRGA: prga_on=1. When prga_fin=1 -> DONE.
  - DONE: holds until start=1 (-> CLR, key relatched) or reset.
  - FAULT: holds until start=1 (-> CLR) or reset.
- Enables: *_on are decoded from the registered state. Each is high for the whole phase and drops on the cycle the next state is entered. An engine's fin is ignored outside its own phase.
- RAM grant:
  - mem_addr/mem_data/mem_wren follow the granted requester combinationally in the same cycle: INIT->init_*, KSA->ksa_*, PRGA->prga_*.
  - In every other state the port is zero with mem_wren=0.
  - A non-granted requester's wren never reaches the RAM.
- Watchdog:
  - Cleared to 0 on entry to INIT, KSA and PRGA; increments every cycle inside those phases.
  - If it equals TIMEOUT_CYCLES-1 and the phase fin is 0 -> FAULT on the next edge.
  - If fin=1 in that same cycle, fin wins and the normal transition is taken.
- Abort: abort=1 in any busy state -> IDLE on the next edge. All on signals drop and the RAM port goes idle; key_out is kept. abort in IDLE, DONE or FAULT is ignored. start and abort together in IDLE/DONE/FAULT: start wins.
- start while busy is ignored.
- key_out only changes on an accepted start.
- reset_n asserted mid-phase: immediate return to reset values, mem_wren=0 asynchronously.

Test Plan:
- Normal run: stubs raise init_fin after 260, ksa_fin after 3080 and prga_fin after 100 active cycles; start with key 0x000249.
  - Phase sequence 1,2,3,4,5,6,7; eng_clr high exactly 1 cycle.
  - key_out=0x000249; done=1; busy=0 at end.
  - mem_wren never high in CLR or the GAP states.
- Grant isolation: in KSA, init_wren=1 and prga_wren=1 with addr 0x55 -> mem_wren only mirrors ksa_wren, and mem_addr equals ksa_addr.
- Timeout: ksa_fin held at 0 -> fault=1 and phase=7 exactly TIMEOUT_CYCLES cycles after KSA entry, ksa_on=0.
  - Repeat with ksa_fin rising on the final counted cycle -> GAP2 is entered, no fault.
- Abort in KSA: abort pulsed at cycle 500 of KSA -> IDLE next cycle, all *_on=0, key_out kept.
  - A following start with key 0x123456 relatches the key and eng_clr pulses.
- Key stability: secret_key changed to 0xFFFFFF mid-run -> key_out stays 0x000249 until the next accepted start.
- Async reset: reset_n low mid-PRGA, between clock edges -> all outputs zero immediately; after release, state=IDLE and a start runs normally.
